// File: rtl/led_display_frame_fetch.sv
// Frame fetch for a HUB75-style LED panel: reads 32-bit RGB pixel words from the frame
// memory, builds one bit-plane of one row-pair in a staging buffer, and hands completed
// rows to the display PHY over valid/ready. The next row-plane is fetched into the
// staging buffer while the PHY holds the current one.
module led_display_frame_fetch #(
  parameter int unsigned NUM_COLS    = 64,
  parameter int unsigned NUM_ROWS    = 32,
  parameter int unsigned BIT_DEPTH   = 4,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  output logic [31:0]           ram_address_out,
  input  logic [31:0]           ram_rdata_in,
  output logic [6*NUM_COLS-1:0] row_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic [3:0]            row_address_out,
  output logic [2:0]            plane_out,
  output logic                  frame_start_out
);

  localparam int unsigned NumReads = 2 * NUM_COLS;
  localparam int unsigned IdxW     = $clog2(NumReads);
  localparam int unsigned RowPairs = NUM_ROWS / 2;
  localparam int unsigned RowW     = 6 * NUM_COLS;
  localparam int unsigned BaseW    = $clog2(RowW);
  localparam int unsigned DrainW   = 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReads - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFull} state_e;

  state_e                 state_q;
  logic [IdxW-1:0]        fetch_idx_q;
  logic [IdxW-1:0]        cap_idx_q;
  logic [DrainW-1:0]      drain_cnt_q;
  logic [RAM_LATENCY-1:0] tag_q;
  logic [3:0]             row_q;
  logic [2:0]             plane_q;
  logic [RowW-1:0]        stage_q;

  logic             transfer;
  logic             capture;
  logic [31:0]      disp_row;
  logic [10:0]      word_addr;
  logic [2:0]       bit_sel;
  logic [7:0]       r_byte, g_byte, b_byte;
  logic [BaseW-1:0] cap_base;
  logic             unused_rdata;

  // Staging buffer hands over when complete and the output register is free or draining.
  assign transfer = (state_q == StFull) && (!row_valid_out || row_ready_in);
  assign capture  = tag_q[RAM_LATENCY-1];

  // Even fetch index reads the top row, odd index the matching bottom row, same column.
  always_comb begin
    disp_row        = 32'(row_q) + (fetch_idx_q[0] ? 32'(RowPairs) : 32'd0);
    word_addr       = 11'(disp_row * NUM_COLS + 32'(fetch_idx_q[IdxW-1:1]));
    ram_address_out = {21'b0, word_addr};
  end

  // Plane 0 is the channel MSB; captured word lands in the top or bottom triple of its column.
  always_comb begin
    bit_sel  = 3'd7 - plane_q;
    r_byte   = ram_rdata_in[23:16];
    g_byte   = ram_rdata_in[15:8];
    b_byte   = ram_rdata_in[7:0];
    cap_base = BaseW'(6 * 32'(cap_idx_q[IdxW-1:1]) + (cap_idx_q[0] ? 32'd0 : 32'd3));
  end

  assign unused_rdata = ^ram_rdata_in[31:24];

  // Fetch sequencer: issue reads, wait out RAM latency, then hold until handed over.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      state_q     <= StIdle;
      fetch_idx_q <= '0;
      drain_cnt_q <= '0;
      row_q       <= '0;
      plane_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q     <= StFetch;
          fetch_idx_q <= '0;
        end
        StFetch: begin
          if (fetch_idx_q == LastIdx) begin
            // Address holds on the last read while draining and full.
            state_q     <= StDrain;
            drain_cnt_q <= '0;
          end else begin
            fetch_idx_q <= fetch_idx_q + IdxW'(1);
          end
        end
        StDrain: begin
          if (drain_cnt_q == DrainW'(RAM_LATENCY - 1)) begin
            state_q <= StFull;
          end else begin
            drain_cnt_q <= drain_cnt_q + DrainW'(1);
          end
        end
        StFull: begin
          if (transfer) begin
            state_q     <= StFetch;
            fetch_idx_q <= '0;
            if (plane_q == 3'(BIT_DEPTH - 1)) begin
              plane_q <= '0;
              row_q   <= (row_q == 4'(RowPairs - 1)) ? 4'd0 : row_q + 4'd1;
            end else begin
              plane_q <= plane_q + 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read-data tags: one bit per issued address, aligned to when its data returns.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      tag_q     <= '0;
      cap_idx_q <= '0;
    end else begin
      tag_q[0] <= (state_q == StFetch);
      for (int i = 1; i < RAM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (capture) begin
        cap_idx_q <= cap_idx_q + IdxW'(1);
      end
    end
  end

  // Staging buffer write of the selected plane bits; untagged data is ignored.
  always_ff @(posedge clk_in) begin
    if (n_reset_in && capture) begin
      stage_q[cap_base +: 3] <= {r_byte[bit_sel], g_byte[bit_sel], b_byte[bit_sel]};
    end
  end

  // Output register: loads on transfer, drops valid only when accepted with nothing ready.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      row_out         <= '0;
      row_valid_out   <= 1'b0;
      row_address_out <= '0;
      plane_out       <= '0;
    end else if (transfer) begin
      row_out         <= stage_q;
      row_valid_out   <= 1'b1;
      row_address_out <= row_q;
      plane_out       <= plane_q;
    end else if (row_valid_out && row_ready_in) begin
      row_valid_out <= 1'b0;
    end
  end

  assign frame_start_out = row_valid_out && (row_address_out == 4'd0) && (plane_out == 3'd0);

endmodule

// File: tb/tb_led_display_frame_fetch.sv
module tb_led_display_frame_fetch;

  localparam int NC = 64;
  localparam int RW = 6 * NC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with RAM_LATENCY = 1
  logic          n_reset, ready, valid, fstart;
  logic [31:0]   ram_addr, rdata;
  logic [RW-1:0] row;
  logic [3:0]    raddr;
  logic [2:0]    plane;

  // Instance with RAM_LATENCY = 3
  logic          n_reset3, ready3, valid3, fstart3;
  logic [31:0]   ram_addr3, rdata3, p3a, p3b;
  logic [RW-1:0] row3;
  logic [3:0]    raddr3;
  logic [2:0]    plane3;

  logic [31:0] mem1 [0:2047];
  logic [31:0] mem3 [0:2047];

  int n_cmp = 0;
  int n_bad = 0;

  led_display_frame_fetch #(.RAM_LATENCY(1)) dut (
    .clk_in          (clk),
    .n_reset_in      (n_reset),
    .ram_address_out (ram_addr),
    .ram_rdata_in    (rdata),
    .row_out         (row),
    .row_valid_out   (valid),
    .row_ready_in    (ready),
    .row_address_out (raddr),
    .plane_out       (plane),
    .frame_start_out (fstart)
  );

  led_display_frame_fetch #(.RAM_LATENCY(3)) dut3 (
    .clk_in          (clk),
    .n_reset_in      (n_reset3),
    .ram_address_out (ram_addr3),
    .ram_rdata_in    (rdata3),
    .row_out         (row3),
    .row_valid_out   (valid3),
    .row_ready_in    (ready3),
    .row_address_out (raddr3),
    .plane_out       (plane3),
    .frame_start_out (fstart3)
  );

  // Frame memory models
  always @(posedge clk) rdata <= mem1[ram_addr[10:0]];
  always @(posedge clk) begin
    p3a    <= mem3[ram_addr3[10:0]];
    p3b    <= p3a;
    rdata3 <= p3b;
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int sel, input int bound, input string tag);
    int n = 0;
    while (((sel == 3) ? valid3 : valid) !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, RW'((sel == 3) ? valid3 : valid), RW'(1));
  endtask

  // Expected row-plane straight from the memory image: top = row r, bottom = row r+16
  function automatic logic [RW-1:0] exp_row(input int r, input int p);
    logic [RW-1:0] e;
    logic [31:0] t, b;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      t = mem1[r*NC + c];
      b = mem1[(r+16)*NC + c];
      e[6*c+5] = t[23-p];
      e[6*c+4] = t[15-p];
      e[6*c+3] = t[7-p];
      e[6*c+2] = b[23-p];
      e[6*c+1] = b[15-p];
      e[6*c+0] = b[7-p];
    end
    return e;
  endfunction

  initial begin
    logic [RW-1:0] exp;
    logic [31:0] want;
    int bad_addr, hold_bad;

    n_reset = 1'b0; ready = 1'b1; n_reset3 = 1'b0; ready3 = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = i;
      mem3[i] = 32'h0080_8080;
    end
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_valid", RW'(valid), RW'(0));
    check("rst_row", row, RW'(0));
    check("rst_row_addr", RW'(raddr), RW'(0));
    check("rst_plane", RW'(plane), RW'(0));
    check("rst_ram_addr", RW'(ram_addr), RW'(0));
    check("rst_fstart", RW'(fstart), RW'(0));

    // First row latency with word = address
    n_reset = 1'b1;
    repeat (130) @(negedge clk);
    check("first_valid_130", RW'(valid), RW'(0));
    @(negedge clk);
    check("first_valid_131", RW'(valid), RW'(1));
    check("first_row_addr", RW'(raddr), RW'(0));
    check("first_plane", RW'(plane), RW'(0));
    check("first_fstart", RW'(fstart), RW'(1));
    check("first_row_data", row, exp_row(0, 0));

    // Two lit pixels, PHY stalled
    n_reset = 1'b0; ready = 1'b0;
    for (int i = 0; i < 2048; i++) mem1[i] = 32'h0;
    mem1[5]         = 32'h00FF_0000;
    mem1[16*NC + 5] = 32'h0000_00FF;
    @(negedge clk);
    n_reset = 1'b1;
    wait_valid(1, 200, "pix_wait");
    exp = '0;
    exp[35] = 1'b1;
    exp[30] = 1'b1;
    check("pix_row", row, exp);
    check("pix_col5", RW'(row[35:30]), RW'(6'b100_001));

    // Hold 500 cycles: outputs stable, exactly 128 reads of (0,1) then address parks
    bad_addr = 0; hold_bad = 0;
    for (int k = 0; k < 500; k++) begin
      want = (k < 128) ? (((k % 2) != 0) ? 32'(16*NC + k/2) : 32'(k/2)) : 32'd1087;
      if (ram_addr !== want) bad_addr++;
      if (valid !== 1'b1 || row !== exp || raddr !== 4'd0 || plane !== 3'd0) hold_bad++;
      @(negedge clk);
    end
    check("hold_outputs", RW'(hold_bad), RW'(0));
    check("hold_ram_addr_seq", RW'(bad_addr), RW'(0));
    ready = 1'b1;
    @(negedge clk);
    check("release_valid", RW'(valid), RW'(1));
    check("release_plane", RW'(plane), RW'(1));
    check("release_row_addr", RW'(raddr), RW'(0));
    check("release_fstart", RW'(fstart), RW'(0));
    check("release_row", row, exp);

    // Free run over a full frame plus the wrap
    n_reset = 1'b0;
    for (int i = 0; i < 2048; i++) mem1[i] = (i * 32'h9E37_79B1) ^ (i << 13) ^ 32'h5A5A_1234;
    @(negedge clk);
    n_reset = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      wait_valid(1, 300, "fr_wait");
      check("fr_row_addr", RW'(raddr), RW'((k / 4) % 16));
      check("fr_plane", RW'(plane), RW'(k % 4));
      check("fr_fstart", RW'(fstart), RW'((k % 64) == 0));
      check("fr_row", row, exp_row((k / 4) % 16, k % 4));
      @(negedge clk);
    end

    // RAM_LATENCY = 3, every pixel 0x808080
    n_reset = 1'b0;
    @(negedge clk);
    n_reset3 = 1'b1;
    repeat (132) @(negedge clk);
    check("l3_valid_132", RW'(valid3), RW'(0));
    @(negedge clk);
    check("l3_valid_133", RW'(valid3), RW'(1));
    check("l3_plane0", RW'(plane3), RW'(0));
    check("l3_fstart", RW'(fstart3), RW'(1));
    check("l3_row_p0", row3, {RW{1'b1}});
    check("l3_ram_addr", RW'(ram_addr3), RW'(0));
    for (int p = 1; p < 4; p++) begin
      @(negedge clk);
      wait_valid(3, 300, "l3_wait");
      check("l3_plane", RW'(plane3), RW'(p));
      check("l3_row_addr", RW'(raddr3), RW'(0));
      check("l3_row_zero", row3, RW'(0));
    end
    n_reset3 = 1'b0;

    // Reset during fetch index 60 of row 3, plane 0
    @(negedge clk);
    n_reset = 1'b1; ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      wait_valid(1, 300, "mr_wait");
      @(negedge clk);
    end
    wait_valid(1, 300, "mr_wait_23");
    ready = 1'b0;
    check("mr_row_addr", RW'(raddr), RW'(2));
    check("mr_plane", RW'(plane), RW'(3));
    repeat (60) @(negedge clk);
    check("mr_fetch_addr", RW'(ram_addr), RW'(3*NC + 30));
    check("mr_valid_held", RW'(valid), RW'(1));
    n_reset = 1'b0;
    @(negedge clk);
    check("mr_valid_cleared", RW'(valid), RW'(0));
    check("mr_row_cleared", row, RW'(0));
    check("mr_row_addr_cleared", RW'(raddr), RW'(0));
    check("mr_plane_cleared", RW'(plane), RW'(0));
    check("mr_ram_addr_cleared", RW'(ram_addr), RW'(0));
    n_reset = 1'b1; ready = 1'b1;
    repeat (130) @(negedge clk);
    check("mr_valid_130", RW'(valid), RW'(0));
    @(negedge clk);
    check("mr_valid_131", RW'(valid), RW'(1));
    check("mr_row_addr", RW'(raddr), RW'(0));
    check("mr_plane", RW'(plane), RW'(0));
    check("mr_fstart", RW'(fstart), RW'(1));
    check("mr_row", row, exp_row(0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
